// File: rtl/traffic_pkg.sv
// Shared light codes, phase encoding and board-count constants for the junction
// phase scheduler.
package traffic_pkg;

    localparam int NUM_BOARDS = 4;

    localparam logic [4:0] RED   = 5'b10000;
    localparam logic [4:0] AMBER = 5'b01000;
    localparam logic [4:0] GREEN = 5'b00111;

    localparam logic [19:0] ALL_RED = {4{RED}};

    typedef enum logic [1:0] {
        PH_ALLRED = 2'd0,
        PH_GREEN  = 2'd1,
        PH_AMBER  = 2'd2
    } phase_t;

    // All four boards RED except board b, which shows the given code.
    function automatic logic [19:0] board_lights(input logic [1:0] b, input logic [4:0] code);
        logic [19:0] v;
        v = ALL_RED;
        v[int'(b)*5 +: 5] = code;
        return v;
    endfunction

endpackage

// File: rtl/signal_phase_scheduler_if.sv
// Request inputs and light-board outputs of one junction, bundled for the scheduler
// (slave) and whoever drives requests and watches the lights (master).
import traffic_pkg::*;

interface signal_phase_scheduler_if;
    logic [3:0]  e;
    logic [3:0]  p;
    logic [19:0] lights;
    logic [1:0]  active_board;
    phase_t      phase;
    logic        phase_start;
    logic        emer_active;

    modport master (
        output e, p,
        input  lights, active_board, phase, phase_start, emer_active
    );

    modport slave (
        input  e, p,
        output lights, active_board, phase, phase_start, emer_active
    );
endinterface

// File: rtl/next_board_sel.sv
// Combinational choice of the next green board: emergency (lowest index) first,
// then load priority scanned from cur+1 round to cur, then plain round-robin.
import traffic_pkg::*;

module next_board_sel (
    input  logic [3:0] e,
    input  logic [3:0] p,
    input  logic [1:0] cur,
    output logic [1:0] next,
    output logic       from_emer
);

    always_comb begin
        // NOTE: every output gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
        next      = cur + 2'd1;
        from_emer = 1'b0;
        if (|e) begin
            from_emer = 1'b1;
            // Descending scan: the last hit, i.e. the lowest set index, wins.
            for (int i = NUM_BOARDS - 1; i >= 0; i--) begin
                if (e[i]) next = 2'(i);
            end
        end else if (|p) begin
            // k = 4 wraps to cur itself; k = 1 (the nearest neighbour) is checked last and wins.
            for (int k = NUM_BOARDS; k >= 1; k--) begin
                if (p[cur + 2'(k)]) next = cur + 2'(k);
            end
        end
    end

endmodule

// File: rtl/signal_phase_scheduler.sv
// Junction phase controller: GREEN -> AMBER -> ALLRED per board with clocked dwell
// counters, emergency preemption and registered light-board outputs.
import traffic_pkg::*;

module signal_phase_scheduler #(
    parameter int GREEN_CYCLES  = 16,
    parameter int AMBER_CYCLES  = 4,
    parameter int ALLRED_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    signal_phase_scheduler_if.slave  bus
);

    localparam int MAX_DWELL = (GREEN_CYCLES >= AMBER_CYCLES)
                             ? ((GREEN_CYCLES >= ALLRED_CYCLES) ? GREEN_CYCLES : ALLRED_CYCLES)
                             : ((AMBER_CYCLES >= ALLRED_CYCLES) ? AMBER_CYCLES : ALLRED_CYCLES);
    localparam int CW = ($clog2(MAX_DWELL) < 1) ? 1 : $clog2(MAX_DWELL);

    phase_t          state;
    logic [CW-1:0]   cnt;
    logic [1:0]      board;
    logic [19:0]     lights;
    logic            phase_start;
    logic            emer_active;

    logic [1:0]      sel_next;
    logic            sel_emer;
    logic [3:0]      other_e;

    next_board_sel u_next_board_sel (
        .e         (bus.e),
        .p         (bus.p),
        .cur       (board),
        .next      (sel_next),
        .from_emer (sel_emer)
    );

    assign other_e = bus.e & ~(4'b0001 << board);

    // NOTE: state and outputs update with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= PH_ALLRED;
            cnt         <= CW'(ALLRED_CYCLES - 1);
            board       <= 2'd3;
            lights      <= ALL_RED;
            phase_start <= 1'b0;
            emer_active <= 1'b0;
        end else begin
            phase_start <= 1'b0;
            case (state)
                PH_GREEN: begin
                    // Another board's emergency cuts green short; our own emergency holds it.
                    if ((|other_e) || (!bus.e[board] && cnt == '0)) begin
                        state  <= PH_AMBER;
                        cnt    <= CW'(AMBER_CYCLES - 1);
                        lights <= board_lights(board, AMBER);
                    end else if (bus.e[board]) begin
                        cnt <= CW'(GREEN_CYCLES - 1);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                PH_AMBER: begin
                    if (cnt == '0) begin
                        state  <= PH_ALLRED;
                        cnt    <= CW'(ALLRED_CYCLES - 1);
                        lights <= ALL_RED;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    // Covers PH_ALLRED and the unused encoding, so the FSM always recovers.
                    if (cnt == '0) begin
                        state       <= PH_GREEN;
                        cnt         <= CW'(GREEN_CYCLES - 1);
                        board       <= sel_next;
                        emer_active <= sel_emer;
                        phase_start <= 1'b1;
                        lights      <= board_lights(sel_next, GREEN);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.lights       = lights;
    assign bus.active_board = board;
    assign bus.phase        = state;
    assign bus.phase_start  = phase_start;
    assign bus.emer_active  = emer_active;

endmodule

// File: tb/tb_signal_phase_scheduler.sv
// Directed bench for signal_phase_scheduler: round-robin timing, priority and
// emergency selection, emergency hold, and asynchronous reset mid-amber.
import traffic_pkg::*;

module tb_signal_phase_scheduler;

    localparam logic [4:0] LR = 5'b10000;
    localparam logic [4:0] LA = 5'b01000;
    localparam logic [4:0] LG = 5'b00111;
    localparam logic [19:0] ALLR = {LR, LR, LR, LR};

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    signal_phase_scheduler_if bus ();

    signal_phase_scheduler dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input phase_t ph, input logic [1:0] ab,
                              input logic [19:0] lt, input logic ps, input logic em);
        check({tag, "_phase"},  32'(bus.phase),        32'(ph));
        check({tag, "_board"},  32'(bus.active_board), 32'(ab));
        check({tag, "_lights"}, 32'(bus.lights),       32'(lt));
        check({tag, "_pstart"}, 32'(bus.phase_start),  32'(ps));
        check({tag, "_emer"},   32'(bus.emer_active),  32'(em));
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Leaves the DUT in the first GREEN cycle of board 0.
    task automatic restart();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tick(2);
    endtask

    initial begin
        bus.e = 4'b0000;
        bus.p = 4'b0000;
        reset = 1'b1;
        tick(2);
        reset = 1'b0;

        // Test 1: plain round-robin, 22-cycle period.
        expect_out("t1_reset", PH_ALLRED, 2'd3, ALLR, 1'b0, 1'b0);
        tick(1);
        expect_out("t1_allred2", PH_ALLRED, 2'd3, ALLR, 1'b0, 1'b0);
        tick(1);
        expect_out("t1_g0_first", PH_GREEN, 2'd0, {LR, LR, LR, LG}, 1'b1, 1'b0);
        tick(1);
        expect_out("t1_g0_second", PH_GREEN, 2'd0, {LR, LR, LR, LG}, 1'b0, 1'b0);
        tick(14);
        expect_out("t1_g0_last", PH_GREEN, 2'd0, {LR, LR, LR, LG}, 1'b0, 1'b0);
        tick(1);
        expect_out("t1_a0_first", PH_AMBER, 2'd0, {LR, LR, LR, LA}, 1'b0, 1'b0);
        tick(3);
        expect_out("t1_a0_last", PH_AMBER, 2'd0, {LR, LR, LR, LA}, 1'b0, 1'b0);
        tick(1);
        expect_out("t1_r0_first", PH_ALLRED, 2'd0, ALLR, 1'b0, 1'b0);
        tick(1);
        expect_out("t1_r0_last", PH_ALLRED, 2'd0, ALLR, 1'b0, 1'b0);
        tick(1);
        expect_out("t1_g1_first", PH_GREEN, 2'd1, {LR, LR, LG, LR}, 1'b1, 1'b0);
        tick(21);
        expect_out("t1_r1_last", PH_ALLRED, 2'd1, ALLR, 1'b0, 1'b0);
        tick(1);
        expect_out("t1_g2_first", PH_GREEN, 2'd2, {LR, LG, LR, LR}, 1'b1, 1'b0);
        tick(22);
        expect_out("t1_g3_first", PH_GREEN, 2'd3, {LG, LR, LR, LR}, 1'b1, 1'b0);
        tick(22);
        expect_out("t1_wrap_g0", PH_GREEN, 2'd0, {LR, LR, LR, LG}, 1'b1, 1'b0);

        // Test 2: load priority on board 3 skips boards 1 and 2.
        restart();
        bus.p = 4'b1000;
        tick(21);
        expect_out("t2_allred_end", PH_ALLRED, 2'd0, ALLR, 1'b0, 1'b0);
        tick(1);
        expect_out("t2_g3", PH_GREEN, 2'd3, {LG, LR, LR, LR}, 1'b1, 1'b0);
        bus.p = 4'b0000;

        // Test 3: emergency on board 2 preempts board 0 at green cycle 5.
        restart();
        tick(4);
        expect_out("t3_g0_c5", PH_GREEN, 2'd0, {LR, LR, LR, LG}, 1'b0, 1'b0);
        bus.e = 4'b0100;
        tick(1);
        expect_out("t3_preempt_a1", PH_AMBER, 2'd0, {LR, LR, LR, LA}, 1'b0, 1'b0);
        tick(3);
        expect_out("t3_a4", PH_AMBER, 2'd0, {LR, LR, LR, LA}, 1'b0, 1'b0);
        tick(1);
        expect_out("t3_r1", PH_ALLRED, 2'd0, ALLR, 1'b0, 1'b0);
        tick(1);
        expect_out("t3_r2", PH_ALLRED, 2'd0, ALLR, 1'b0, 1'b0);
        tick(1);
        expect_out("t3_g2_emer", PH_GREEN, 2'd2, {LR, LG, LR, LR}, 1'b1, 1'b1);
        bus.e = 4'b0000;

        // Test 4: own-board emergency holds green; green ends 16 cycles after release.
        restart();
        bus.e = 4'b0001;
        tick(30);
        expect_out("t4_held", PH_GREEN, 2'd0, {LR, LR, LR, LG}, 1'b0, 1'b0);
        bus.e = 4'b0000;
        tick(15);
        expect_out("t4_last_green", PH_GREEN, 2'd0, {LR, LR, LR, LG}, 1'b0, 1'b0);
        tick(1);
        expect_out("t4_amber", PH_AMBER, 2'd0, {LR, LR, LR, LA}, 1'b0, 1'b0);

        // Test 5: emergency beats priority; lowest emergency index wins.
        restart();
        tick(21);
        bus.e = 4'b0110;
        bus.p = 4'b1000;
        tick(1);
        expect_out("t5_g1_emer", PH_GREEN, 2'd1, {LR, LR, LG, LR}, 1'b1, 1'b1);
        bus.e = 4'b0000;
        bus.p = 4'b0000;

        // Test 6: asynchronous reset between edges during board 1 amber.
        tick(16);
        expect_out("t6_a1", PH_AMBER, 2'd1, {LR, LR, LA, LR}, 1'b0, 1'b1);
        #3;
        reset = 1'b1;
        #1;
        expect_out("t6_async_reset", PH_ALLRED, 2'd3, ALLR, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        tick(1);
        expect_out("t6_allred2", PH_ALLRED, 2'd3, ALLR, 1'b0, 1'b0);
        tick(1);
        expect_out("t6_g0", PH_GREEN, 2'd0, {LR, LR, LR, LG}, 1'b1, 1'b0);
        tick(22);
        expect_out("t6_g1", PH_GREEN, 2'd1, {LR, LR, LG, LR}, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
